// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 8x8 multiplier: FSM states and the
// step-counter / nibble widths used by the datapath.
package mult_pkg;

  localparam int STEP_W = 2;
  localparam int NIB    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_seq_8bit_if.sv
// Start/ready/done handshake between the execute stage (master) and the
// sequential multiplier (slave).
interface mult_seq_8bit_if;

  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] prod;

  modport master (output start, a, b, input ready, busy, done, prod);
  modport slave  (input start, a, b, output ready, busy, done, prod);

endinterface

// File: rtl/mult_seq_8bit_arr.sv
// Purely combinational 4x4 unsigned array multiplier, shared by all four
// partial-product steps of the sequential multiplier.
module ArrMult_4bit
  import mult_pkg::*;
(
  input  logic [NIB-1:0]   a,
  input  logic [NIB-1:0]   b,
  output logic [2*NIB-1:0] prod
);

  // One shifted row of the multiplicand per set multiplier bit.
  always_comb begin
    prod = '0;
    for (int i = 0; i < NIB; i++) begin
      if (b[i]) begin
        prod = prod + ({{NIB{1'b0}}, a} << i);
      end
    end
  end

endmodule

// File: rtl/mult_seq_8bit.sv
// Multi-cycle 8x8 unsigned multiplier: four nibble partial products from one
// 4x4 array multiplier, shifted and accumulated into a 16-bit product.
module mult_seq_8bit
  import mult_pkg::*;
#(
  parameter bit CLEAR_ON_START = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  mult_seq_8bit_if.slave     bus
);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [7:0]          a_q, a_d;
  logic [7:0]          b_q, b_d;
  logic [15:0]         acc_q, acc_d;
  logic [15:0]         prod_q, prod_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [NIB-1:0]      a_nib;
  logic [NIB-1:0]      b_nib;
  logic [2*NIB-1:0]    pp;
  logic [15:0]         pp_sh;

  // step[0] picks the high nibble of a, step[1] the high nibble of b.
  assign a_nib = step_q[0] ? a_q[7:4] : a_q[3:0];
  assign b_nib = step_q[1] ? b_q[7:4] : b_q[3:0];

  ArrMult_4bit u_arr (
    .a    (a_nib),
    .b    (b_nib),
    .prod (pp)
  );

  always_comb begin
    case (step_q)
      2'd0:    pp_sh = {8'h00, pp};
      2'd3:    pp_sh = {pp, 8'h00};
      default: pp_sh = {4'h0, pp, 4'h0};
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          step_d  = '0;
          state_d = MUL;
          if (CLEAR_ON_START) begin
            acc_d  = '0;
            prod_d = '0;
          end
        end
      end
      MUL: begin
        step_d = step_q + 2'd1;
        acc_d  = (step_q == 2'd0) ? pp_sh : acc_q + pp_sh;
        if (step_q == 2'd3) begin
          prod_d  = acc_q + pp_sh;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status flags are decoded from the next state so they leave as flops.
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == MUL);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.prod  = prod_q;

endmodule
